// File: rtl/config_loader.sv
// Serial configuration loader: accepts host words and shifts them LSB-first
// into the fabric chain through a one-entry holding register and a shift engine.
module config_loader #(
  parameter int BITS   = 4480,
  parameter int WORD_W = 32
) (
  input  logic                       prog_clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [WORD_W-1:0]          word_data,
  input  logic                       word_valid,
  output logic                       word_ready,
  output logic                       prog_in,
  output logic                       prog_en,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(BITS+1)-1:0]  bit_cnt
);

  localparam int N_WORDS   = (BITS + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = BITS - (N_WORDS - 1) * WORD_W;
  localparam int CNT_W     = $clog2(BITS + 1);
  localparam int WC_W      = $clog2(N_WORDS + 1);
  localparam int EB_W      = $clog2(WORD_W + 1);

  localparam logic [CNT_W-1:0] BITS_C   = CNT_W'(BITS);
  localparam logic [WC_W-1:0]  N_C      = WC_W'(N_WORDS);
  localparam logic [WC_W-1:0]  N_LAST_C = WC_W'(N_WORDS - 1);
  localparam logic [EB_W-1:0]  LAST_C   = EB_W'(LAST_BITS);
  localparam logic [EB_W-1:0]  FULL_C   = EB_W'(WORD_W);
  localparam logic [EB_W-1:0]  ONE_C    = EB_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WC_W-1:0]     words_q, words_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic                hold_last_q, hold_last_d;
  logic [WORD_W-1:0]   eng_q, eng_d;
  logic [EB_W-1:0]     eng_bits_q, eng_bits_d;
  logic                done_q, done_d;
  logic                prog_en_q, prog_en_d;
  logic                prog_in_q, prog_in_d;
  logic                shift, load_eng, accept;

  assign word_ready = (state_q == S_LOAD) && !hold_full_q && (words_q < N_C);
  assign busy       = (state_q == S_LOAD);
  assign done       = done_q;
  assign prog_en    = prog_en_q;
  assign prog_in    = prog_in_q;
  assign bit_cnt    = bit_cnt_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    words_d     = words_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    hold_last_d = hold_last_q;
    eng_d       = eng_q;
    eng_bits_d  = eng_bits_q;
    done_d      = done_q;
    prog_en_d   = 1'b0;
    prog_in_d   = 1'b0;
    shift       = 1'b0;
    load_eng    = 1'b0;
    accept      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_LOAD;
          bit_cnt_d   = '0;
          words_d     = '0;
          hold_d      = '0;
          hold_full_d = 1'b0;
          hold_last_d = 1'b0;
          eng_d       = '0;
          eng_bits_d  = '0;
          done_d      = 1'b0;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d     = S_IDLE;
          hold_full_d = 1'b0;
          eng_bits_d  = '0;
        end else begin
          shift    = (eng_bits_q != '0);
          // Refill on the engine's last bit so a streaming load has no bubbles.
          load_eng = hold_full_q && ((eng_bits_q == '0) || (eng_bits_q == ONE_C));
          accept   = word_valid && word_ready;
          if (shift) begin
            prog_en_d  = 1'b1;
            prog_in_d  = eng_q[0];
            eng_d      = eng_q >> 1;
            eng_bits_d = eng_bits_q - ONE_C;
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          end
          if (load_eng) begin
            eng_d       = hold_q;
            eng_bits_d  = hold_last_q ? LAST_C : FULL_C;
            hold_full_d = 1'b0;
          end
          if (accept) begin
            hold_d      = word_data;
            hold_full_d = 1'b1;
            hold_last_d = (words_q == N_LAST_C);
            words_d     = words_q + WC_W'(1);
          end
          if (bit_cnt_d == BITS_C) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      words_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      hold_last_q <= 1'b0;
      eng_q       <= '0;
      eng_bits_q  <= '0;
      done_q      <= 1'b0;
      prog_en_q   <= 1'b0;
      prog_in_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      words_q     <= words_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      hold_last_q <= hold_last_d;
      eng_q       <= eng_d;
      eng_bits_q  <= eng_bits_d;
      done_q      <= done_d;
      prog_en_q   <= prog_en_d;
      prog_in_q   <= prog_in_d;
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Randomized bench for config_loader: the expected serial stream is the word
// list read bit by bit, LSB first, truncated to the chain length.
module tb_config_loader;

  localparam int BITS = 4480;
  localparam int WW   = 32;
  localparam int NW   = 140;

  logic        prog_clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0, abort = 1'b0, word_valid = 1'b0;
  logic [31:0] word_data = '0;
  logic        word_ready, prog_in, prog_en, busy, done;
  logic [12:0] bit_cnt;

  logic        s_start = 1'b0, s_abort = 1'b0, s_word_valid = 1'b0;
  logic [31:0] s_word_data = '0;
  logic        s_word_ready, s_prog_in, s_prog_en, s_busy, s_done;
  logic [6:0]  s_bit_cnt;

  always #5 prog_clk = ~prog_clk;

  config_loader dut (
    .prog_clk(prog_clk), .rst_n(rst_n), .start(start), .abort(abort),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .prog_in(prog_in), .prog_en(prog_en), .busy(busy), .done(done), .bit_cnt(bit_cnt)
  );

  config_loader #(.BITS(100), .WORD_W(32)) dut_s (
    .prog_clk(prog_clk), .rst_n(rst_n), .start(s_start), .abort(s_abort),
    .word_data(s_word_data), .word_valid(s_word_valid), .word_ready(s_word_ready),
    .prog_in(s_prog_in), .prog_en(s_prog_en), .busy(s_busy), .done(s_done), .bit_cnt(s_bit_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [31:0] words [0:NW-1];
  logic        cap [0:BITS-1];
  int          cyc = 0;
  bit          mon_on = 1'b0;
  int          cap_n, run, maxrun, first_en, zero_viol = 0;

  always @(posedge prog_clk) cyc++;

  always @(negedge prog_clk) begin
    if (!prog_en && prog_in) zero_viol++;
    if (mon_on) begin
      if (prog_en) begin
        if (cap_n < BITS) cap[cap_n] = prog_in;
        cap_n++;
        run++;
        if (run > maxrun) maxrun = run;
        if (first_en < 0) first_en = cyc;
      end else begin
        run = 0;
      end
    end
  end

  task automatic fill_words(input int ramp);
    for (int i = 0; i < NW; i++)
      words[i] = ramp ? (i * 32'h01010101) : $urandom;
  endtask

  // mode: 0 continuous, 1 valid 1-0-0, 2 random valid + stray start, 3 sparse (starving)
  task automatic run_load(input int mode, input int stop_at, output int first_acc);
    int idx, guard;
    bit acc, v;
    cap_n = 0; run = 0; maxrun = 0; first_en = -1; mon_on = 1'b1;
    first_acc = -1; idx = 0; guard = 0;
    start = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0;
    chk("start_clears_bit_cnt", bit_cnt, 0);
    chk("busy_after_start", busy, 1);
    while (!done && !(stop_at >= 0 && int'(bit_cnt) == stop_at) && guard < 20000) begin
      case (mode)
        0: v = 1'b1;
        1: v = (guard % 3 == 0);
        2: v = 1'($urandom_range(0, 1));
        default: v = ($urandom_range(0, 39) == 0);
      endcase
      if (idx >= NW) v = 1'b0;
      word_valid = v;
      word_data  = v ? words[idx] : $urandom;
      if (mode == 2 && $urandom_range(0, 63) == 0) start = 1'b1;
      acc = word_valid && word_ready;
      if (acc && first_acc < 0) first_acc = cyc + 1;
      @(posedge prog_clk); #1;
      start = 1'b0;
      if (acc) idx++;
      guard++;
    end
    word_valid = 1'b0;
    chk("load_within_budget", guard < 20000, 1);
  endtask

  task automatic check_full(input string nm, input int first_acc, input bit contig);
    int mism;
    @(posedge prog_clk); #1;
    mon_on = 1'b0;
    mism = 0;
    for (int j = 0; j < BITS && j < cap_n; j++)
      if (cap[j] !== words[j / WW][j % WW]) mism++;
    chk({nm, "_stream"}, mism, 0);
    chk({nm, "_en_cycles"}, cap_n, BITS);
    chk({nm, "_bit_cnt"}, bit_cnt, BITS);
    chk({nm, "_done"}, done, 1);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_en_low_after"}, prog_en, 0);
    chk({nm, "_first_latency"}, first_en - first_acc, 2);
    if (contig) chk({nm, "_no_bubbles"}, maxrun, BITS);
  endtask

  initial begin
    int fa, mism, s_en, sidx;
    bit acc;
    logic [31:0] sw [0:3];

    #2 rst_n = 1'b0;
    #1;
    chk("rst_prog_en", prog_en, 0);
    chk("rst_prog_in", prog_in, 0);
    chk("rst_word_ready", word_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    @(negedge prog_clk); rst_n = 1'b1;
    @(posedge prog_clk); #1;

    abort = 1'b1;
    @(posedge prog_clk); #1;
    abort = 1'b0;
    chk("abort_idle_busy", busy, 0);

    fill_words(1);
    run_load(0, -1, fa);
    check_full("stream", fa, 1'b1);

    abort = 1'b1;
    @(posedge prog_clk); #1;
    abort = 1'b0;
    chk("abort_done_keeps_done", done, 1);
    chk("abort_done_keeps_cnt", bit_cnt, BITS);

    run_load(1, -1, fa);
    check_full("bp100", fa, 1'b0);

    fill_words(0);
    run_load(2, -1, fa);
    check_full("rand", fa, 1'b0);

    fill_words(0);
    run_load(3, -1, fa);
    check_full("starve", fa, 1'b0);

    fill_words(0);
    run_load(0, 1000, fa);
    abort = 1'b1;
    @(posedge prog_clk); #1;
    abort = 1'b0;
    chk("abort_prog_en", prog_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", word_ready, 0);
    chk("abort_bit_cnt", bit_cnt, 1000);
    repeat (3) @(posedge prog_clk);
    #1;
    chk("abort_bit_cnt_frozen", bit_cnt, 1000);
    run_load(0, -1, fa);
    check_full("reload", fa, 1'b1);

    fill_words(0);
    run_load(2, 2000, fa);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_prog_en", prog_en, 0);
    chk("arst_prog_in", prog_in, 0);
    chk("arst_busy", busy, 0);
    chk("arst_bit_cnt", bit_cnt, 0);
    chk("arst_ready", word_ready, 0);
    @(negedge prog_clk); rst_n = 1'b1;
    repeat (3) @(posedge prog_clk);
    #1;
    chk("arst_waits_idle", busy, 0);
    run_load(0, -1, fa);
    check_full("arst_reload", fa, 1'b1);

    for (int i = 0; i < 4; i++) sw[i] = $urandom;
    s_start = 1'b1;
    @(posedge prog_clk); #1;
    s_start = 1'b0;
    sidx = 0; s_en = 0; mism = 0;
    for (int k = 0; k < 300 && !s_done; k++) begin
      s_word_valid = 1'b1;
      s_word_data  = (sidx < 4) ? sw[sidx] : $urandom;
      acc = s_word_valid && s_word_ready;
      @(posedge prog_clk); #1;
      if (acc) begin
        sidx++;
        if (sidx == 4) chk("s_ready_after_last", s_word_ready, 0);
      end
      if (s_prog_en) begin
        if (s_en < 100 && s_prog_in !== sw[s_en / 32][s_en % 32]) mism++;
        s_en++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      acc = s_word_valid && s_word_ready;
      @(posedge prog_clk); #1;
      if (acc) sidx++;
      if (s_prog_en) s_en++;
    end
    s_word_valid = 1'b0;
    chk("s_en_cycles", s_en, 100);
    chk("s_stream", mism, 0);
    chk("s_words_accepted", sidx, 4);
    chk("s_bit_cnt", s_bit_cnt, 100);
    chk("s_done", s_done, 1);

    chk("prog_in_zero_when_idle", zero_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter BITS, default 4480, meaning total configuration chain length in bits.
REQ-002 SHALL have parameter WORD_W, default 32, meaning host word width in bits.
REQ-003 SHALL have port prog_clk  input  1  configuration clock; the block's only clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle load request.
REQ-006 SHALL have port abort  input  1  cancel load in progress.
REQ-007 SHALL have port word_data  input  WORD_W  bitstream word; bit 0 is the lowest chain index.
REQ-008 SHALL have port word_valid  input  1  word_data valid.
REQ-009 SHALL have port word_ready  output  1  block accepts word this cycle.
REQ-010 SHALL have port prog_in  output  1  serial configuration bit to the fabric chain.
REQ-011 SHALL have port prog_en  output  1  chain shift enable; the fabric samples prog_in on prog_clk rise while high.
REQ-012 SHALL have port busy  output  1  load in progress.
REQ-013 SHALL have port done  output  1  full chain loaded.
REQ-014 SHALL have port bit_cnt  output  clog2(BITS+1)  bits shifted since last start.

Function
REQ-015 SHALL implement states IDLE, LOAD, DONE; busy = (state == LOAD).
REQ-016 IDLE/DONE: start=1 -> LOAD next cycle; bit_cnt, word counter, holding register and shift register cleared; done cleared.
REQ-017 start SHALL be ignored while in LOAD.
REQ-018 Total words N = ceil(BITS/WORD_W), which is 140 at defaults; the last word SHALL contribute only BITS - (N-1)*WORD_W low bits, with upper bits discarded.
REQ-019 SHALL contain a one-entry holding register; word_ready = (state == LOAD) and holding empty and words_accepted < N.
REQ-020 A word SHALL be accepted only on word_valid and word_ready both high; word_valid with word_ready low SHALL be ignored, and no data SHALL be lost or duplicated.
REQ-021 SHALL contain a shift engine holding the active word. When the active word is empty and the holding register is full, the holding word SHALL move to the engine in the same cycle, freeing the holding register.
REQ-022 Each cycle the engine holds bits, prog_en (registered) SHALL be 1 on the next cycle, with prog_in = current LSB; the engine SHALL shift right 1 and bit_cnt SHALL increment by 1.
REQ-023 With continuous word_valid, prog_en SHALL stay high for all BITS cycles with no bubbles; the first prog_en rises 2 cycles after the first word accept.
REQ-024 Starvation (engine empty, holding empty): prog_en = 0 and bit_cnt SHALL hold; shifting resumes the cycle after a new word arrives.
REQ-025 When bit_cnt reaches BITS, state SHALL go to DONE. The last prog_en-high cycle coincides with the DONE transition; prog_en = 0 the following cycle; done = 1 and holds until the next start or reset.
REQ-026 prog_en SHALL never be high for more than BITS cycles per load.
REQ-027 abort in LOAD SHALL force IDLE next cycle: prog_en = 0, word_ready = 0, done = 0, bit_cnt frozen at its value.
REQ-028 abort SHALL take priority over start and word accept in the same cycle; abort in IDLE/DONE has no effect.
REQ-029 prog_in SHALL be 0 whenever prog_en = 0.

Reset
REQ-030 rst_n = 0 SHALL force immediately, without a clock: state IDLE, prog_en = 0, prog_in = 0, word_ready = 0, busy = 0, done = 0, bit_cnt = 0, holding and engine empty.
REQ-031 Reset asserted mid-LOAD SHALL abandon the load; after release the block SHALL wait in IDLE for start.

Verification
REQ-032 Streaming: start, then 140 words with word_valid held high, word i = i*0x01010101 -> prog_en high for exactly 4480 consecutive cycles; serial stream equals the words LSB-first in word order; done = 1; bit_cnt = 4480.
REQ-033 Backpressure/starvation: word_valid toggling 1-0-0 pattern -> prog_en gaps only during starvation; serial stream identical to REQ-032; bit_cnt = 4480 at done.
REQ-034 Partial last word: BITS = 100, WORD_W = 32, 4 words of 0xFFFFFFFF -> exactly 100 prog_en cycles; last word accepted with only 4 bits shifted; word_ready = 0 after the 4th accept.
REQ-035 Abort: abort after bit_cnt = 1000 -> next cycle prog_en = 0, busy = 0, done = 0, bit_cnt = 1000; a subsequent start clears bit_cnt to 0 and a full reload completes normally.
REQ-036 Async reset: rst_n low at bit_cnt = 2000, asynchronous to the clock edge -> all outputs zero before the next prog_clk rise; start after release reloads from word 0.
REQ-037 End-to-end: config_loader drives the IO fabric with the all-zero/routing pattern -> fabric outputs match the reference model after done.
